// File: rtl/mul_req_driver.sv
// mul_req_driver: sequences one multiplier command at a time.
//    Accepts a command on the req_* handshake, drives the multiplier (mul_*)
//    from registered copies until it reports ready or the cycle budget runs
//    out, then presents the result on the rsp_* handshake.
// Ports:
//    clk, rst_n          - clock, asynchronous active-low reset
//    req_valid_i/ready_o - command handshake; req_op_i is a mul_opcode_e
//                          value passed through to the multiplier unchanged
//    req_a/b/c_i, req_signed_i, req_subword_i, req_imm_i - command fields
//    rsp_valid_o/ready_i - response handshake
//    rsp_result_o        - multiplier result (0 on timeout)
//    rsp_cycles_o        - number of EXEC cycles spent
//    rsp_err_o           - 1 when the request timed out
//    mul_*_o             - multiplier drive; dot/clpx controls tied to 0
//    mul_result_i, mul_multicycle_i, mul_ready_i - multiplier return
module mul_req_driver #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [2:0]  req_op_i,
   input  logic [31:0] req_a_i,
   input  logic [31:0] req_b_i,
   input  logic [31:0] req_c_i,
   input  logic [1:0]  req_signed_i,
   input  logic        req_subword_i,
   input  logic [4:0]  req_imm_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_result_o,
   output logic [3:0]  rsp_cycles_o,
   output logic        rsp_err_o,
   output logic        mul_enable_o,
   output logic [2:0]  mul_operator_o,
   output logic [1:0]  mul_short_signed_o,
   output logic        mul_short_subword_o,
   output logic [31:0] mul_operand_a_o,
   output logic [31:0] mul_operand_b_o,
   output logic [31:0] mul_operand_c_o,
   output logic [4:0]  mul_imm_o,
   output logic        mul_ex_ready_o,
   output logic [1:0]  mul_dot_signed_o,
   output logic [31:0] mul_dot_op_a_o,
   output logic [31:0] mul_dot_op_b_o,
   output logic [31:0] mul_dot_op_c_o,
   output logic        mul_is_clpx_o,
   output logic [1:0]  mul_clpx_shift_o,
   output logic        mul_clpx_img_o,
   input  logic [31:0] mul_result_i,
   input  logic        mul_multicycle_i,
   input  logic        mul_ready_i
);

   typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_e;

   localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT);

   state_e     state;
   logic [3:0] cnt;
   logic [3:0] cnt_inc;
   logic       accept;
   logic       unused_multicycle;

   // Staying in EXEC depends only on mul_ready_i; the multicycle flag adds
   // no extra information for this driver.
   assign unused_multicycle = mul_multicycle_i;

   assign req_ready_o = (state == IDLE) | ((state == HOLD) & rsp_ready_i);
   assign accept      = req_valid_i & req_ready_o;

   // Count including the current EXEC cycle, saturating at 15.
   assign cnt_inc = (cnt == 4'd15) ? 4'd15 : cnt + 4'd1;

   assign mul_dot_signed_o = '0;
   assign mul_dot_op_a_o   = '0;
   assign mul_dot_op_b_o   = '0;
   assign mul_dot_op_c_o   = '0;
   assign mul_is_clpx_o    = 1'b0;
   assign mul_clpx_shift_o = '0;
   assign mul_clpx_img_o   = 1'b0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state               <= IDLE;
         cnt                 <= '0;
         rsp_valid_o         <= 1'b0;
         rsp_result_o        <= '0;
         rsp_cycles_o        <= '0;
         rsp_err_o           <= 1'b0;
         mul_enable_o        <= 1'b0;
         mul_ex_ready_o      <= 1'b0;
         mul_operator_o      <= '0;
         mul_short_signed_o  <= '0;
         mul_short_subword_o <= 1'b0;
         mul_operand_a_o     <= '0;
         mul_operand_b_o     <= '0;
         mul_operand_c_o     <= '0;
         mul_imm_o           <= '0;
      end else begin
         case (state)
            EXEC: begin
               cnt <= cnt_inc;
               if (mul_ready_i) begin
                  state          <= HOLD;
                  mul_enable_o   <= 1'b0;
                  mul_ex_ready_o <= 1'b0;
                  rsp_valid_o    <= 1'b1;
                  rsp_result_o   <= mul_result_i;
                  rsp_cycles_o   <= cnt_inc;
                  rsp_err_o      <= 1'b0;
               end else if (cnt_inc == TIMEOUT_CNT) begin
                  state          <= HOLD;
                  mul_enable_o   <= 1'b0;
                  mul_ex_ready_o <= 1'b0;
                  rsp_valid_o    <= 1'b1;
                  rsp_result_o   <= '0;
                  rsp_cycles_o   <= TIMEOUT_CNT;
                  rsp_err_o      <= 1'b1;
               end
            end
            default: begin
               // IDLE and HOLD share the accept path so a response drained
               // in HOLD can be followed by a new command on the same edge.
               if (state == HOLD && rsp_ready_i) begin
                  state       <= IDLE;
                  rsp_valid_o <= 1'b0;
               end
               if (accept) begin
                  state               <= EXEC;
                  cnt                 <= '0;
                  mul_enable_o        <= 1'b1;
                  mul_ex_ready_o      <= 1'b1;
                  mul_operator_o      <= req_op_i;
                  mul_short_signed_o  <= req_signed_i;
                  mul_short_subword_o <= req_subword_i;
                  mul_operand_a_o     <= req_a_i;
                  mul_operand_b_o     <= req_b_i;
                  mul_operand_c_o     <= req_c_i;
                  mul_imm_o           <= req_imm_i;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mul_req_driver.sv
// Testbench for mul_req_driver: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model. The bench also acts
// as the multiplier, answering each accepted request after a chosen latency.
module tb_mul_req_driver;

   localparam int unsigned TO = 15;
   localparam logic [2:0] MUL_MAC32 = 3'b000;
   localparam logic [2:0] MUL_H     = 3'b110;

   logic        clk;
   logic        rst_n;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [2:0]  req_op_i;
   logic [31:0] req_a_i, req_b_i, req_c_i;
   logic [1:0]  req_signed_i;
   logic        req_subword_i;
   logic [4:0]  req_imm_i;
   logic        rsp_valid_o;
   logic        rsp_ready_i;
   logic [31:0] rsp_result_o;
   logic [3:0]  rsp_cycles_o;
   logic        rsp_err_o;
   logic        mul_enable_o;
   logic [2:0]  mul_operator_o;
   logic [1:0]  mul_short_signed_o;
   logic        mul_short_subword_o;
   logic [31:0] mul_operand_a_o, mul_operand_b_o, mul_operand_c_o;
   logic [4:0]  mul_imm_o;
   logic        mul_ex_ready_o;
   logic [1:0]  mul_dot_signed_o;
   logic [31:0] mul_dot_op_a_o, mul_dot_op_b_o, mul_dot_op_c_o;
   logic        mul_is_clpx_o;
   logic [1:0]  mul_clpx_shift_o;
   logic        mul_clpx_img_o;
   logic [31:0] mul_result_i;
   logic        mul_multicycle_i;
   logic        mul_ready_i;

   mul_req_driver #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_op_i(req_op_i), .req_a_i(req_a_i), .req_b_i(req_b_i), .req_c_i(req_c_i),
      .req_signed_i(req_signed_i), .req_subword_i(req_subword_i), .req_imm_i(req_imm_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_result_o(rsp_result_o), .rsp_cycles_o(rsp_cycles_o), .rsp_err_o(rsp_err_o),
      .mul_enable_o(mul_enable_o), .mul_operator_o(mul_operator_o),
      .mul_short_signed_o(mul_short_signed_o), .mul_short_subword_o(mul_short_subword_o),
      .mul_operand_a_o(mul_operand_a_o), .mul_operand_b_o(mul_operand_b_o),
      .mul_operand_c_o(mul_operand_c_o), .mul_imm_o(mul_imm_o),
      .mul_ex_ready_o(mul_ex_ready_o),
      .mul_dot_signed_o(mul_dot_signed_o), .mul_dot_op_a_o(mul_dot_op_a_o),
      .mul_dot_op_b_o(mul_dot_op_b_o), .mul_dot_op_c_o(mul_dot_op_c_o),
      .mul_is_clpx_o(mul_is_clpx_o), .mul_clpx_shift_o(mul_clpx_shift_o),
      .mul_clpx_img_o(mul_clpx_img_o),
      .mul_result_i(mul_result_i), .mul_multicycle_i(mul_multicycle_i),
      .mul_ready_i(mul_ready_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned checks = 0;
   int unsigned errors = 0;

   // Stimulus knobs for the next cycle.
   logic        d_req_valid, d_rsp_ready, d_subword;
   logic [2:0]  d_op;
   logic [31:0] d_a, d_b, d_c, d_res;
   logic [1:0]  d_signed;
   logic [4:0]  d_imm;
   int unsigned d_lat;

   // Transaction-level model: one request in flight or one response pending.
   bit          m_busy, m_pend;
   int unsigned m_k, m_lat;
   logic [2:0]  c_op;
   logic [31:0] c_a, c_b, c_c;
   logic [1:0]  c_signed;
   logic        c_subword;
   logic [4:0]  c_imm;
   logic [31:0] m_res;
   logic [3:0]  m_cyc;
   logic        m_err;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic rand_cmd();
      d_op      = 3'($urandom_range(0, 6));
      d_a       = $urandom;
      d_b       = $urandom;
      d_c       = $urandom;
      d_signed  = 2'($urandom);
      d_subword = 1'($urandom);
      d_imm     = 5'($urandom);
   endtask

   task automatic step();
      logic        exp_rr;
      int unsigned k;
      @(negedge clk);
      req_valid_i   = d_req_valid;
      req_op_i      = d_op;
      req_a_i       = d_a;
      req_b_i       = d_b;
      req_c_i       = d_c;
      req_signed_i  = d_signed;
      req_subword_i = d_subword;
      req_imm_i     = d_imm;
      rsp_ready_i   = d_rsp_ready;
      mul_result_i  = d_res;
      k = m_k + 1;
      if (m_busy) begin
         mul_ready_i      = (k == m_lat);
         mul_multicycle_i = (k != m_lat);
      end else begin
         mul_ready_i      = 1'($urandom);
         mul_multicycle_i = 1'($urandom);
      end
      #1;
      exp_rr = !m_busy && (!m_pend || d_rsp_ready);
      chk("req_ready", req_ready_o, exp_rr);
      chk("rsp_valid", rsp_valid_o, m_pend);
      chk("mul_enable", mul_enable_o, m_busy);
      chk("mul_ex_ready", mul_ex_ready_o, m_busy);
      chk("tied_zero", {31'd0, |{mul_dot_signed_o, mul_dot_op_a_o, mul_dot_op_b_o,
          mul_dot_op_c_o, mul_is_clpx_o, mul_clpx_shift_o, mul_clpx_img_o}}, 32'd0);
      if (m_busy) begin
         chk("mul_operator", mul_operator_o, c_op);
         chk("mul_operand_a", mul_operand_a_o, c_a);
         chk("mul_operand_b", mul_operand_b_o, c_b);
         chk("mul_operand_c", mul_operand_c_o, c_c);
         chk("mul_fields", {mul_short_signed_o, mul_short_subword_o, mul_imm_o},
             {c_signed, c_subword, c_imm});
      end
      if (m_pend) begin
         chk("rsp_result", rsp_result_o, m_res);
         chk("rsp_cycles", rsp_cycles_o, m_cyc);
         chk("rsp_err", rsp_err_o, m_err);
      end
      // Advance the model over the coming edge.
      if (m_busy) begin
         if (k == m_lat) begin
            m_busy = 0; m_pend = 1; m_res = d_res; m_cyc = 4'(k); m_err = 1'b0;
         end else if (k == TO) begin
            m_busy = 0; m_pend = 1; m_res = '0; m_cyc = 4'(TO); m_err = 1'b1;
         end else begin
            m_k = k;
         end
      end else begin
         if (m_pend && d_rsp_ready) m_pend = 0;
         if (d_req_valid && exp_rr) begin
            m_busy = 1; m_k = 0; m_lat = d_lat;
            c_op = d_op; c_a = d_a; c_b = d_b; c_c = d_c;
            c_signed = d_signed; c_subword = d_subword; c_imm = d_imm;
         end
      end
      @(posedge clk);
   endtask

   initial begin
      int unsigned n;
      rst_n = 1'b0;
      req_valid_i = 0; req_op_i = '0; req_a_i = '0; req_b_i = '0; req_c_i = '0;
      req_signed_i = '0; req_subword_i = 0; req_imm_i = '0; rsp_ready_i = 0;
      mul_result_i = 32'hDEAD_BEEF; mul_multicycle_i = 1; mul_ready_i = 1;
      m_busy = 0; m_pend = 0; m_k = 0; m_lat = 1;
      d_req_valid = 1; d_rsp_ready = 0; d_lat = 1; d_res = '0;
      d_op = '0; d_a = '0; d_b = '0; d_c = '0; d_signed = '0; d_subword = 0; d_imm = '0;

      // Reset state, with a valid request present that must be ignored.
      req_valid_i = 1;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_req_ready", req_ready_o, 1);
      chk("reset_rsp_valid", rsp_valid_o, 0);
      chk("reset_mul_enable", mul_enable_o, 0);
      chk("reset_outputs_zero", {31'd0, |{rsp_result_o, rsp_cycles_o, rsp_err_o,
          mul_ex_ready_o, mul_operator_o, mul_operand_a_o, mul_imm_o}}, 32'd0);
      req_valid_i = 0;
      @(negedge clk);
      rst_n = 1'b1;

      // MAC32 3*5+7, multiplier ready in the first EXEC cycle.
      d_req_valid = 1; d_op = MUL_MAC32; d_a = 3; d_b = 5; d_c = 7;
      d_lat = 1; d_res = 32'd22; d_rsp_ready = 0;
      step();
      d_req_valid = 0;
      step();
      #2;
      chk("mac32_valid", rsp_valid_o, 1);
      chk("mac32_result", rsp_result_o, 32'd22);
      chk("mac32_cycles", rsp_cycles_o, 4'd1);
      chk("mac32_err", rsp_err_o, 0);
      d_rsp_ready = 1;
      step();

      // MUL_H, four busy cycles then 0x1234.
      d_req_valid = 1; d_op = MUL_H; d_a = 32'h1111_0000; d_b = 32'h0000_2222;
      d_c = 0; d_lat = 5; d_res = 32'h1234; d_rsp_ready = 0;
      step();
      d_req_valid = 0;
      repeat (5) step();
      #2;
      chk("mulh_result", rsp_result_o, 32'h0000_1234);
      chk("mulh_cycles", rsp_cycles_o, 4'd5);

      // Response stalled three cycles while a new request waits.
      d_req_valid = 1; rand_cmd();
      repeat (3) step();
      #2;
      chk("stall_valid", rsp_valid_o, 1);
      chk("stall_result", rsp_result_o, 32'h0000_1234);
      d_req_valid = 0; d_rsp_ready = 1;
      step();
      #2;
      chk("stall_released", rsp_valid_o, 0);

      // Multiplier never ready: timeout after TO EXEC cycles.
      d_req_valid = 1; rand_cmd(); d_lat = 20; d_rsp_ready = 0;
      step();
      d_req_valid = 0;
      #2;
      n = 0;
      repeat (20) begin
         n += 32'(mul_enable_o);
         step();
         #2;
      end
      chk("timeout_exec_cycles", n, 15);
      chk("timeout_err", rsp_err_o, 1);
      chk("timeout_result", rsp_result_o, 0);
      chk("timeout_cycles", rsp_cycles_o, 4'd15);

      // Back-to-back requests with the response drained immediately.
      d_rsp_ready = 1; d_req_valid = 1; rand_cmd(); d_lat = 1; d_res = 32'hA5A5_0001;
      step();
      step();
      rand_cmd(); d_res = 32'hA5A5_0002;
      step();
      #2;
      chk("b2b_enable", mul_enable_o, 1);
      chk("b2b_no_valid", rsp_valid_o, 0);
      d_req_valid = 0;
      repeat (3) step();

      // Reset pulse in the second EXEC cycle of a MUL_H request.
      d_req_valid = 1; rand_cmd(); d_op = MUL_H; d_lat = 10; d_rsp_ready = 1;
      step();
      d_req_valid = 0;
      step();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_enable", mul_enable_o, 0);
      chk("rst_mid_valid", rsp_valid_o, 0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      m_busy = 0; m_pend = 0; m_k = 0;
      #1;
      chk("rst_mid_ready", req_ready_o, 1);
      repeat (12) step();

      // Randomized traffic.
      repeat (3000) begin
         d_req_valid = ($urandom_range(0, 2) != 0);
         d_rsp_ready = 1'($urandom);
         d_res       = $urandom;
         d_lat       = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 20)
                                                  : $urandom_range(1, 6);
         rand_cmd();
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
